// File: rtl/vga_sync_pkg.sv
// VGA timing package: default 640x480@60 constants, the shared coordinate
// type and small helpers that derive totals and sync pulse boundaries.
package vga_timing_pkg;

    localparam int COORD_W         = 10;
    localparam int COORD_MAX_TOTAL = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    function automatic int axis_total(input int disp, input int front,
                                      input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int sync_first(input int disp, input int front);
        return disp + front;
    endfunction

    function automatic int sync_last(input int disp, input int front, input int sync);
        return disp + front + sync - 1;
    endfunction

endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// Pixel-rate tick: one-clk pulse every TICK_DIV clocks, first pulse on the
// TICK_DIV-th clock after reset release.
module pixel_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 1) begin : g_bad_div
            $error("pixel_tick_gen: TICK_DIV must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

    // Wrap the divider counter after TICK_DIV-1.
    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (tick_cnt_q == CNT_LAST) begin
            tick_cnt_d = '0;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // With TICK_DIV=1 the counter is pinned at 0 and the tick is always high.
    assign p_tick = (tick_cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel counters, registered syncs aligned with the counts,
// combinational active-video decode and a frame-start pulse.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY   = H_DISPLAY_DEF,
    parameter int   H_FRONT     = H_FRONT_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BACK      = H_BACK_DEF,
    parameter int   V_DISPLAY   = V_DISPLAY_DEF,
    parameter int   V_FRONT     = V_FRONT_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BACK      = V_BACK_DEF,
    parameter int   TICK_DIV    = 4,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_tick
);

    localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t HS_FIRST = coord_t'(sync_first(H_DISPLAY, H_FRONT));
    localparam coord_t HS_LAST  = coord_t'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
    localparam coord_t VS_FIRST = coord_t'(sync_first(V_DISPLAY, V_FRONT));
    localparam coord_t VS_LAST  = coord_t'(sync_last(V_DISPLAY, V_FRONT, V_SYNC));

    generate
        if (H_TOTAL > COORD_MAX_TOTAL || V_TOTAL > COORD_MAX_TOTAL) begin : g_bad_totals
            $error("vga_sync: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
        end
    endgenerate

    logic   tick;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_tick_q, frame_tick_d;

    pixel_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .p_tick(tick)
    );

    // Next counts; syncs decode the next counts so they switch with them.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        frame_tick_d = 1'b0;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d          = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        hsync_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Counter, sync and frame-start registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign p_tick     = tick;
    assign pixel_x    = x_q;
    assign pixel_y    = y_q;
    assign frame_tick = frame_tick_q;
    assign video_on   = (int'(x_q) < H_DISPLAY) && (int'(y_q) < V_DISPLAY);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: three instances (default timing, a tiny raster so whole
// frames fit in a short run, and TICK_DIV=1 with active-high syncs) checked
// every cycle against a closed-form timing model, plus a constant vector table
// and hand-written reset / frame sequences.
module tb_vga_sync;

    typedef struct {
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
        logic pt;
        logic ft;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
        exp_t c;
    } sb_t;

    typedef struct {
        int   n;
        int   x;
        int   y;
        logic hs;
        logic von;
        logic pt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       hsync_a, vsync_a, video_on_a, p_tick_a, frame_tick_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       hsync_b, vsync_b, video_on_b, p_tick_b, frame_tick_b;
    logic [9:0] pixel_x_b, pixel_y_b;
    logic       hsync_c, vsync_c, video_on_c, p_tick_c, frame_tick_c;
    logic [9:0] pixel_x_c, pixel_y_c;

    int checks = 0;
    int errors = 0;
    int n_clk  = 0;
    sb_t sb_q[$];

    int hs_low_a  = 0;
    int hs_high_c = 0;
    int vs_low_b  = 0;
    int last_ft_b = -1;

    vga_sync u_a (
        .clk(clk), .reset(reset), .hsync(hsync_a), .vsync(vsync_a),
        .video_on(video_on_a), .p_tick(p_tick_a), .pixel_x(pixel_x_a),
        .pixel_y(pixel_y_a), .frame_tick(frame_tick_a)
    );

    vga_sync #(
        .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .TICK_DIV(3), .SYNC_ACTIVE(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .hsync(hsync_b), .vsync(vsync_b),
        .video_on(video_on_b), .p_tick(p_tick_b), .pixel_x(pixel_x_b),
        .pixel_y(pixel_y_b), .frame_tick(frame_tick_b)
    );

    vga_sync #(
        .TICK_DIV(1), .SYNC_ACTIVE(1'b1)
    ) u_c (
        .clk(clk), .reset(reset), .hsync(hsync_c), .vsync(vsync_c),
        .video_on(video_on_c), .p_tick(p_tick_c), .pixel_x(pixel_x_c),
        .pixel_y(pixel_y_c), .frame_tick(frame_tick_c)
    );

    always #5 clk = ~clk;

    // Expected outputs n clock edges after reset release.
    function automatic exp_t model(input int n, input int d,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input logic act);
        exp_t m;
        int ht  = hd + hf + hsw + hb;
        int vt  = vd + vf + vsw + vb;
        int pos = (n / d) % (ht * vt);
        m.x   = pos % ht;
        m.y   = pos / ht;
        m.pt  = ((n % d) == d - 1);
        m.ft  = (n > 0) && ((n % d) == 0) && (pos == 0);
        m.hs  = (m.x >= hd + hf && m.x < hd + hf + hsw) ? act : ~act;
        m.vs  = (m.y >= vd + vf && m.y < vd + vf + vsw) ? act : ~act;
        m.von = (m.x < hd) && (m.y < vd);
        return m;
    endfunction

    function automatic sb_t expect_all(input int n);
        sb_t s;
        s.a = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        s.b = model(n, 3, 10, 2, 3, 2, 6, 2, 2, 3, 1'b0);
        s.c = model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input exp_t e, input int x, input int y,
                           input logic hs, input logic vs, input logic von,
                           input logic pt, input logic ft);
        chk({tag, ".pixel_x"}, x, e.x);
        chk({tag, ".pixel_y"}, y, e.y);
        chk({tag, ".hsync"}, int'(hs), int'(e.hs));
        chk({tag, ".vsync"}, int'(vs), int'(e.vs));
        chk({tag, ".video_on"}, int'(von), int'(e.von));
        chk({tag, ".p_tick"}, int'(pt), int'(e.pt));
        chk({tag, ".frame_tick"}, int'(ft), int'(e.ft));
    endtask

    // Scoreboard producer: advance the edge count and queue the expectation.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n_clk = 0;
            sb_q.delete();
        end else begin
            n_clk = n_clk + 1;
        end
        sb_q.push_back(expect_all(n_clk));
    end

    // Scoreboard consumer: compare all three instances mid-cycle.
    always @(negedge clk) begin
        sb_t s;
        if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            chk_dut("a", s.a, int'(pixel_x_a), int'(pixel_y_a), hsync_a, vsync_a,
                    video_on_a, p_tick_a, frame_tick_a);
            chk_dut("b", s.b, int'(pixel_x_b), int'(pixel_y_b), hsync_b, vsync_b,
                    video_on_b, p_tick_b, frame_tick_b);
            chk_dut("c", s.c, int'(pixel_x_c), int'(pixel_y_c), hsync_c, vsync_c,
                    video_on_c, p_tick_c, frame_tick_c);
        end
    end

    // Pulse-width and frame-interval bookkeeping.
    always @(negedge clk) begin
        if (reset) begin
            last_ft_b = -1;
        end else begin
            if (n_clk < 3200 && hsync_a == 1'b0) hs_low_a++;
            if (n_clk < 800 && hsync_c == 1'b1) hs_high_c++;
            if (n_clk < 663 && vsync_b == 1'b0) vs_low_b++;
            if (frame_tick_b) begin
                if (last_ft_b >= 0) chk("b.frame_interval_clks", n_clk - last_ft_b, 663);
                last_ft_b = n_clk;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_clk=%0d", n_clk);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        bit   found;

        tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{3,    0,   0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{4,    1,   0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{7,    1,   0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{2559, 639, 0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{2560, 640, 0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{2623, 655, 0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{2624, 656, 0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3007, 751, 0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3008, 752, 0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{3199, 799, 0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{3200, 0,   1, 1'b1, 1'b1, 1'b0};

        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst.a.hsync", int'(hsync_a), 1);
        chk("rst.a.vsync", int'(vsync_a), 1);
        chk("rst.a.video_on", int'(video_on_a), 1);
        chk("rst.c.p_tick", int'(p_tick_c), 1);
        @(negedge clk);
        reset = 1'b0;

        // Constant vectors for the default-timing instance.
        foreach (tbl[i]) begin
            while (n_clk < tbl[i].n) @(negedge clk);
            #1;
            chk("vec.a.pixel_x", int'(pixel_x_a), tbl[i].x);
            chk("vec.a.pixel_y", int'(pixel_y_a), tbl[i].y);
            chk("vec.a.hsync", int'(hsync_a), int'(tbl[i].hs));
            chk("vec.a.video_on", int'(video_on_a), int'(tbl[i].von));
            chk("vec.a.p_tick", int'(p_tick_a), int'(tbl[i].pt));
        end

        while (n_clk < 3400) @(negedge clk);
        chk("a.hsync_low_clks_line0", hs_low_a, 384);
        chk("c.hsync_high_clks_line0", hs_high_c, 96);
        chk("b.vsync_low_clks_frame0", vs_low_b, 102);

        // Mid-frame asynchronous reset on the small raster at x=13, y=4.
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (((n_clk / 3) % 221) == 81) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("b.reach_x13_y4", int'(found), 1);
        chk("pre_rst.b.hsync_active", int'(hsync_b), 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async.a.pixel_x", int'(pixel_x_a), 0);
        chk("async.b.pixel_x", int'(pixel_x_b), 0);
        chk("async.b.pixel_y", int'(pixel_y_b), 0);
        chk("async.b.hsync", int'(hsync_b), 1);
        chk("async.b.vsync", int'(vsync_b), 1);
        chk("async.b.frame_tick", int'(frame_tick_b), 0);
        chk("async.b.p_tick", int'(p_tick_b), 0);
        chk("async.c.hsync", int'(hsync_c), 0);
        chk("async.c.pixel_x", int'(pixel_x_c), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Restart must repeat power-up timing; first tick on the 3rd/4th edge.
        repeat (2) @(posedge clk);
        #1;
        chk("restart.b.p_tick_edge2", int'(p_tick_b), 1);
        chk("restart.a.p_tick_edge2", int'(p_tick_a), 0);
        @(posedge clk);
        #1;
        chk("restart.a.p_tick_edge3", int'(p_tick_a), 1);
        chk("restart.b.pixel_x_edge3", int'(pixel_x_b), 1);
        repeat (800) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
